// File: rtl/fsm.sv
// Brew sequencer: on an ok rising edge, dispense five ingredients in order.
// Each step opens one valve and pulses start_timer. The sequencer then waits
// for the external timer to report t_expired before moving to the next step.
// Outputs are registered. They are updated together with the state, so they
// always match the registered state and step and never follow an input
// combinationally.
module fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       ok,
    input  logic       t_expired,
    output logic [2:0] ing_type,
    output logic       start_timer,
    output logic [7:3] ingredientes
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAST_STEP = 3'd5;
    localparam logic [2:0] CODE_DONE = 3'd6;

    state_t     state;
    logic [2:0] step;
    logic       ok_q;

    // State, step counter, ok edge detector and registered Moore outputs.
    // Each output register is written with the value that belongs to the
    // state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            step         <= 3'd0;
            ok_q         <= 1'b0;
            ing_type     <= 3'd0;
            start_timer  <= 1'b0;
            ingredientes <= 5'b00000;
        end else begin
            // ok_q follows ok in every state, so an ok level that is held
            // through a brew cannot look like a new press back in IDLE.
            ok_q <= ok;
            case (state)
                IDLE: begin
                    if (ok && !ok_q) begin
                        state        <= LOAD;
                        step         <= 3'd1;
                        ing_type     <= 3'd1;
                        start_timer  <= 1'b1;
                        ingredientes <= 5'b00001;
                    end
                end
                LOAD: begin
                    // t_expired is ignored here. The timer was only started this cycle.
                    state       <= WAIT;
                    start_timer <= 1'b0;
                end
                WAIT: begin
                    if (t_expired) begin
                        if (step < LAST_STEP) begin
                            state        <= LOAD;
                            step         <= step + 3'd1;
                            ing_type     <= step + 3'd1;
                            start_timer  <= 1'b1;
                            ingredientes <= ingredientes << 1;
                        end else begin
                            state        <= DONE;
                            ing_type     <= CODE_DONE;
                            ingredientes <= 5'b00000;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    ing_type <= 3'd0;
                end
                default: begin
                    state        <= IDLE;
                    ing_type     <= 3'd0;
                    start_timer  <= 1'b0;
                    ingredientes <= 5'b00000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm.sv
// Directed bench for the brew sequencer. Inputs change on the falling edge.
// Outputs are checked on the next falling edge, after the rising edge has
// taken in those inputs.
module tb_fsm;

    logic       clk;
    logic       reset;
    logic       ok;
    logic       t_expired;
    logic [2:0] ing_type;
    logic       start_timer;
    logic [7:3] ingredientes;

    int checks = 0;
    int errors = 0;

    fsm dut (
        .clk          (clk),
        .reset        (reset),
        .ok           (ok),
        .t_expired    (t_expired),
        .ing_type     (ing_type),
        .start_timer  (start_timer),
        .ingredientes (ingredientes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {ing_type, start_timer, ingredientes} for a code and a pulse level.
    function automatic logic [8:0] e(input int code, input bit st);
        logic [4:0] v;
        v = 5'b00000;
        if (code >= 1 && code <= 5) v[code-1] = 1'b1;
        return {3'(code), st, v};
    endfunction

    task automatic chk(input string tag, input logic [8:0] ex);
        logic [8:0] got;
        got = {ing_type, start_timer, ingredientes};
        checks++;
        assert (got === ex) else begin
            errors++;
            $error("FAIL %s got type=%0d st=%b ing=%b exp type=%0d st=%b ing=%b",
                   tag, got[8:6], got[5], got[4:0], ex[8:6], ex[5], ex[4:0]);
        end
    endtask

    // Apply inputs for the next rising edge, then check at the following falling edge.
    task automatic step(input logic o, input logic t, input string tag, input logic [8:0] ex);
        ok        = o;
        t_expired = t;
        @(negedge clk);
        chk(tag, ex);
    endtask

    // One complete brew started by an ok rising edge (ok must be low beforehand).
    task automatic brew(input bit hold, input int gap, input bit midok);
        step(1'b1, 1'b0, "ld1", e(1, 1'b1));
        for (int s = 1; s <= 5; s++) begin
            for (int k = 0; k < gap; k++)
                step(hold | (midok && s == 3 && k == 0), 1'b0, "wait", e(s, 1'b0));
            if (s < 5) step(hold, 1'b1, "load", e(s + 1, 1'b1));
            else       step(hold, 1'b1, "done", e(6, 1'b0));
        end
        step(hold, 1'b0, "back_idle", e(0, 1'b0));
    endtask

    initial begin
        reset     = 1'b0;
        ok        = 1'b0;
        t_expired = 1'b0;
        @(negedge clk);

        // Held in reset with random inputs.
        for (int i = 0; i < 6; i++)
            step(1'($urandom_range(1)), 1'($urandom_range(1)), "in_reset", e(0, 1'b0));
        ok = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "idle", e(0, 1'b0));

        // t_expired in IDLE does nothing.
        step(1'b0, 1'b1, "idle_t", e(0, 1'b0));
        step(1'b0, 1'b0, "idle_t2", e(0, 1'b0));

        // Full brew with widely spaced timer pulses.
        brew(1'b0, 50, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "post_full", e(0, 1'b0));

        // ok held through the brew and after it: exactly one brew.
        brew(1'b1, 3, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "held_ok", e(0, 1'b0));
        step(1'b0, 1'b0, "ok_low", e(0, 1'b0));
        brew(1'b0, 2, 1'b0);

        // An ok press in the middle of the brew is ignored and is not queued.
        step(1'b0, 1'b0, "pre_mid", e(0, 1'b0));
        brew(1'b0, 4, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "no_extra", e(0, 1'b0));

        // t_expired high only during LOAD is ignored; then async reset during step 3.
        step(1'b1, 1'b0, "s_ld1", e(1, 1'b1));
        step(1'b0, 1'b1, "t_in_load", e(1, 1'b0));
        step(1'b0, 1'b0, "stay_wait", e(1, 1'b0));
        step(1'b0, 1'b0, "stay_wait2", e(1, 1'b0));
        step(1'b0, 1'b1, "s_ld2", e(2, 1'b1));
        step(1'b0, 1'b0, "s_w2", e(2, 1'b0));
        step(1'b0, 1'b1, "s_ld3", e(3, 1'b1));
        step(1'b0, 1'b0, "s_w3", e(3, 1'b0));
        #2 reset = 1'b0;
        #1 chk("async_rst", e(0, 1'b0));
        @(negedge clk);
        chk("rst_hold", e(0, 1'b0));
        reset = 1'b1;
        step(1'b0, 1'b0, "rst_idle", e(0, 1'b0));
        step(1'b0, 1'b1, "rst_idle_t", e(0, 1'b0));
        brew(1'b0, 2, 1'b0);

        // t_expired held high: steps advance every two cycles.
        step(1'b1, 1'b1, "ht_ld1", e(1, 1'b1));
        for (int s = 1; s <= 5; s++) begin
            step(1'b0, 1'b1, "ht_wait", e(s, 1'b0));
            if (s < 5) step(1'b0, 1'b1, "ht_load", e(s + 1, 1'b1));
            else       step(1'b0, 1'b1, "ht_done", e(6, 1'b0));
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, "ht_idle", e(0, 1'b0));
        step(1'b0, 1'b0, "final_idle", e(0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
